reset_sequencer: RTL and testbench

Parametrised reset synchroniser and sequencer for one clock domain. Asserts every output reset asynchronously and immediately. Releases the outputs synchronously, in order, after a metastability-safe synchroniser chain and a minimum hold (stretch) period. Sits between the board/PLL reset and the domain's subsystems so they leave reset in a fixed, staggered order; also supports an optional synchronous software reset.

---
 rtl/reset_sequencer.sv | 159 +++++++++++++++
 tb/tb_reset_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset synchroniser and staggered release sequencer for a single clock domain.
// Optional synchronous software reset is enabled by defining RST_SEQ_SOFT_RST_EN.
module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_OUT        = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               arst_in_n,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               rst_done
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int CH_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN
    } state_t;

    generate
        if (SYNC_STAGES < 2)    $error("SYNC_STAGES must be at least 2");
        if (NUM_OUT < 1)        $error("NUM_OUT must be at least 1");
        if (STRETCH_CYCLES < 1) $error("STRETCH_CYCLES must be at least 1");
        if (STAGGER_CYCLES < 1) $error("STAGGER_CYCLES must be at least 1");
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;
    logic                   soft_req;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [NUM_OUT-1:0] out_d;
    logic               done_d;

    // NOTE: assertion is asynchronous, release is synchronous; only stage 0 can
    // ever sample arst_in_n going high, so metastability stays in that flop.
    always_ff @(posedge clk or negedge arst_in_n) begin
        if (!arst_in_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_n = sync_q[SYNC_STAGES-1];

`ifdef RST_SEQ_SOFT_RST_EN
    assign soft_req = soft_rst_req;
`else
    // Port kept for a uniform footprint; the request has no effect in this build.
    logic unused_soft_rst_req;
    assign unused_soft_rst_req = soft_rst_req;
    assign soft_req            = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        out_d   = rst_out_n;
        done_d  = rst_done;

        unique case (state_q)
            ST_HOLD: begin
                if (sync_n) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end
            end

            ST_STRETCH: begin
                if (cnt_q == STRETCH_LAST) begin
                    out_d[0] = 1'b1;
                    ch_d     = CH_W'(1);
                    cnt_d    = '0;
                    if (NUM_OUT == 1) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (cnt_q == STAGGER_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (CH_W'(i) == ch_q) out_d[i] = 1'b1;
                    end
                    // Last channel: stop here so ch never wraps past NUM_OUT-1.
                    if (ch_q == CH_LAST) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                ch_d    = '0;
                out_d   = '0;
                done_d  = 1'b0;
            end
        endcase

        // Software reset restarts the stretch; in HOLD the synchroniser owns release.
        if (soft_req && (state_q != ST_HOLD)) begin
            state_d = ST_STRETCH;
            cnt_d   = '0;
            ch_d    = '0;
            out_d   = '0;
            done_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge arst_in_n) begin
        if (!arst_in_n) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            ch_q      <= '0;
            rst_out_n <= '0;
            rst_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            rst_out_n <= out_d;
            rst_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a minimal-parameter
// instance (SYNC_STAGES=3, NUM_OUT=1, STRETCH_CYCLES=1) sharing clock and resets.
module tb_reset_sequencer;

    logic       clk;
    logic       arst_in_n;
    logic       soft_rst_req;
    logic [3:0] rst_out_n0;
    logic       rst_done0;
    logic [0:0] rst_out_n1;
    logic       rst_done1;

    int n_vec;
    int n_err;

    reset_sequencer #(
        .SYNC_STAGES   (2),
        .NUM_OUT       (4),
        .STRETCH_CYCLES(16),
        .STAGGER_CYCLES(4)
    ) dut0 (
        .clk         (clk),
        .arst_in_n   (arst_in_n),
        .soft_rst_req(soft_rst_req),
        .rst_out_n   (rst_out_n0),
        .rst_done    (rst_done0)
    );

    reset_sequencer #(
        .SYNC_STAGES   (3),
        .NUM_OUT       (1),
        .STRETCH_CYCLES(1),
        .STAGGER_CYCLES(4)
    ) dut1 (
        .clk         (clk),
        .arst_in_n   (arst_in_n),
        .soft_rst_req(soft_rst_req),
        .rst_out_n   (rst_out_n1),
        .rst_done    (rst_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: channel k is high once rel >= 16 + 4k cycles past the stretch start.
    function automatic logic [3:0] exp_thermo(input int rel);
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (rel >= 16 + 4 * k);
        return v;
    endfunction

    task automatic expect_all_low(input string name);
        n_vec++;
        if (rst_out_n0 !== 4'b0000 || rst_done0 !== 1'b0 ||
            rst_out_n1 !== 1'b0 || rst_done1 !== 1'b0) begin
            n_err++;
            $display("FAIL %s: dut0 out=%b done=%b dut1 out=%b done=%b, want all 0",
                     name, rst_out_n0, rst_done0, rst_out_n1, rst_done1);
        end
    endtask

    // Caller has released arst_in_n so that the next posedge is E1.
    task automatic track_release(input string name, input int n_edges);
        logic [3:0] e0;
        logic       e1;
        for (int e = 1; e <= n_edges; e++) begin
            @(posedge clk);
            #1;
            e0 = exp_thermo(e - 3);
            e1 = (e >= 5);
            n_vec++;
            if (rst_out_n0 !== e0 || rst_done0 !== (e >= 31) ||
                rst_out_n1[0] !== e1 || rst_done1 !== e1) begin
                n_err++;
                $display("FAIL %s E%0d: dut0 out=%b done=%b (want %b/%b) dut1 out=%b done=%b (want %b/%b)",
                         name, e, rst_out_n0, rst_done0, e0, (e >= 31),
                         rst_out_n1, rst_done1, e1, e1);
            end
        end
    endtask

    task automatic test_reset;
        arst_in_n    = 1'b0;
        soft_rst_req = 1'b0;
        #1;
        expect_all_low("reset_t0");
        repeat (5) @(posedge clk);
        #1;
        expect_all_low("reset_held");
    endtask

    task automatic test_power_on;
        @(negedge clk);
        arst_in_n = 1'b1;
        track_release("power_on", 35);
    endtask

    task automatic test_async_in_run;
        @(negedge clk);
        #1 arst_in_n = 1'b0;
        #1 expect_all_low("async_glitch");
        #2 arst_in_n = 1'b1;
        track_release("async_restart", 35);
    endtask

    task automatic test_mid_release;
        @(negedge clk);
        arst_in_n = 1'b0;
        #1 expect_all_low("mid_rel_pre");
        @(negedge clk);
        arst_in_n = 1'b1;
        track_release("mid_rel_first", 25);
        arst_in_n = 1'b0;
        #1 expect_all_low("mid_rel_drop");
        repeat (2) @(negedge clk);
        arst_in_n = 1'b1;
        track_release("mid_rel_restart", 35);
    endtask

`ifdef RST_SEQ_SOFT_RST_EN
    // Pulses sampled at T (j=0) and T+20 (j=20); rel counts edges since the latest one.
    task automatic test_soft_reset;
        int         rel;
        logic [3:0] e0;
        logic       e1;
        for (int j = 0; j <= 40; j++) begin
            @(negedge clk);
            soft_rst_req = (j == 0 || j == 20);
            @(posedge clk);
            #1;
            rel = (j >= 20) ? j - 20 : j;
            e0  = exp_thermo(rel);
            e1  = (rel >= 1);
            n_vec++;
            if (rst_out_n0 !== e0 || rst_done0 !== (rel >= 28) ||
                rst_out_n1[0] !== e1 || rst_done1 !== e1) begin
                n_err++;
                $display("FAIL soft_rst T+%0d: dut0 out=%b done=%b (want %b/%b) dut1 out=%b done=%b (want %b/%b)",
                         j, rst_out_n0, rst_done0, e0, (rel >= 28),
                         rst_out_n1, rst_done1, e1, e1);
            end
        end
        @(negedge clk);
        soft_rst_req = 1'b0;
    endtask
`else
    task automatic test_soft_reset;
        @(negedge clk);
        soft_rst_req = 1'b1;
        for (int j = 1; j <= 50; j++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (rst_out_n0 !== 4'b1111 || rst_done0 !== 1'b1 ||
                rst_out_n1 !== 1'b1 || rst_done1 !== 1'b1) begin
                n_err++;
                $display("FAIL soft_ignored cyc%0d: dut0 out=%b done=%b dut1 out=%b done=%b, want all 1",
                         j, rst_out_n0, rst_done0, rst_out_n1, rst_done1);
            end
        end
        @(negedge clk);
        soft_rst_req = 1'b0;
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_power_on();
        test_async_in_run();
        test_mid_release();
        test_soft_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
